// File: rtl/electronic_lock_pkg.sv
// Shared types and constants for the two-button combination lock.
package electronic_lock_pkg;

  typedef enum logic {
    LOCKED,
    OPEN
  } lock_state_t;

  typedef enum logic [1:0] {
    DIG_NONE,
    DIG_0,
    DIG_1,
    DIG_ABORT
  } digit_t;

  localparam logic [3:0] DEFAULT_CODE = 4'b1011;

endpackage

// File: rtl/lock_input_decode.sv
// Classifies the two button levels into one digit event per cycle.
module lock_input_decode
  import electronic_lock_pkg::*;
(
  input  logic   b0_i,
  input  logic   b1_i,
  output digit_t dig_o
);

  always_comb begin
    dig_o = DIG_NONE;
    unique case ({b1_i, b0_i})
      2'b01:   dig_o = DIG_0;
      2'b10:   dig_o = DIG_1;
      2'b11:   dig_o = DIG_ABORT;
      default: dig_o = DIG_NONE;
    endcase
  end

endmodule

// File: rtl/electronic_lock.sv
// Sliding-window combination lock driving the latch enable.
// Optional idle timeout discarding stale history: ELECTRONIC_LOCK_TIMEOUT_EN.
module electronic_lock
  import electronic_lock_pkg::*;
#(
  parameter int unsigned           CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0]   CODE           = CODE_LEN'(DEFAULT_CODE),
  parameter int unsigned           UNLOCK_CYCLES  = 8,
  parameter int unsigned           TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic b0,
  input  logic b1,
  output logic unlock
);

  localparam int unsigned CW = $clog2(CODE_LEN + 1);
  localparam int unsigned TW = $clog2(UNLOCK_CYCLES + 1);
  localparam logic [CW-1:0] CntMax    = CW'(CODE_LEN);
  localparam logic [TW-1:0] TimerLoad = TW'(UNLOCK_CYCLES - 1);

  if (CODE_LEN < 1 || CODE_LEN > 16 || UNLOCK_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("electronic_lock: parameter out of range");
  end

  digit_t dig;

  lock_input_decode u_decode (
    .b0_i  (b0),
    .b1_i  (b1),
    .dig_o (dig)
  );

  lock_state_t         state_q, state_d;
  logic [CODE_LEN-1:0] hist_q, hist_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                unlock_q, unlock_d;

`ifdef ELECTRONIC_LOCK_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IdleMax = IW'(TIMEOUT_CYCLES);
  logic [IW-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
`ifdef ELECTRONIC_LOCK_TIMEOUT_EN
    idle_d   = '0;
`endif
    unique case (state_q)
      LOCKED: begin
        unique case (dig)
          DIG_0, DIG_1: begin
            hist_d = CODE_LEN'({hist_q, dig == DIG_1});
            cnt_d  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
          end
          DIG_ABORT: begin
            hist_d = '0;
            cnt_d  = '0;
          end
          default: begin
`ifdef ELECTRONIC_LOCK_TIMEOUT_EN
            idle_d = idle_q + 1'b1;
            if (idle_d == IdleMax) begin
              hist_d = '0;
              cnt_d  = '0;
              idle_d = '0;
            end
`endif
          end
        endcase
        // Match is judged on the updated window so the completing digit counts.
        if (cnt_d == CntMax && hist_d == CODE) begin
          state_d = OPEN;
          timer_d = TimerLoad;
          hist_d  = '0;
          cnt_d   = '0;
        end
      end
      OPEN: begin
        if (timer_q == '0) state_d = LOCKED;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = LOCKED;
    endcase
    unlock_d = (state_d == OPEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOCKED;
      hist_q   <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      unlock_q <= 1'b0;
`ifdef ELECTRONIC_LOCK_TIMEOUT_EN
      idle_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      unlock_q <= unlock_d;
`ifdef ELECTRONIC_LOCK_TIMEOUT_EN
      idle_q   <= idle_d;
`endif
    end
  end

  assign unlock = unlock_q;

endmodule

// File: tb/tb_electronic_lock.sv
// Directed self-checking bench for electronic_lock with default parameters.
module tb_electronic_lock;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b0  = 1'b0;
  logic b1  = 1'b0;
  logic unlock;

  int n_checks = 0;
  int n_bad    = 0;

  electronic_lock dut (
    .clk    (clk),
    .rst    (rst),
    .b0     (b0),
    .b1     (b1),
    .unlock (unlock)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of buttons; returns just after the sampling edge.
  task automatic step(input logic v1, input logic v0);
    b1 = v1;
    b0 = v0;
    @(posedge clk);
    #1;
  endtask

  // Enter digit d (2 = idle, 3 = abort) and check unlock afterwards.
  task automatic key(input string tag, input int d, input logic exp);
    unique case (d)
      0:       step(1'b0, 1'b1);
      1:       step(1'b1, 1'b0);
      3:       step(1'b1, 1'b1);
      default: step(1'b0, 1'b0);
    endcase
    check_bit(tag, unlock, exp);
  endtask

  // Remaining 7 high cycles of a grant, then the drop; digits fed while open.
  task automatic grant_tail(input string tag, input int d);
    for (int i = 0; i < 7; i++) key(tag, d, 1'b1);
    key({tag, "_end"}, 2, 1'b0);
  endtask

  initial begin
    // 1: reset dominates toggling buttons
    key("rst_a", 1, 1'b0);
    key("rst_b", 0, 1'b0);
    key("rst_c", 1, 1'b0);
    key("rst_d", 1, 1'b0);
    rst = 1'b0;
    // History empty after reset: 0,1,1 alone must not open.
    key("post_rst0", 0, 1'b0);
    key("post_rst1", 1, 1'b0);
    key("post_rst2", 1, 1'b0);
    key("clr0", 3, 1'b0);

    // 2: basic code 1,0,1,1
    key("basic0", 1, 1'b0);
    key("basic1", 0, 1'b0);
    key("basic2", 1, 1'b0);
    key("basic3", 1, 1'b1);
    grant_tail("basic_hold", 2);

    // 3: sliding window 1,1,0,1,1
    key("slide0", 1, 1'b0);
    key("slide1", 1, 1'b0);
    key("slide2", 0, 1'b0);
    key("slide3", 1, 1'b0);
    key("slide4", 1, 1'b1);
    grant_tail("slide_hold", 2);

    // 4: abort mid-entry, then full code through the leftover window
    key("abort0", 1, 1'b0);
    key("abort1", 0, 1'b0);
    key("abort2", 3, 1'b0);
    key("abort3", 1, 1'b0);
    key("abort4", 1, 1'b0);
    key("after_ab0", 1, 1'b0);
    key("after_ab1", 0, 1'b0);
    key("after_ab2", 1, 1'b0);
    key("after_ab3", 1, 1'b1);
    grant_tail("after_ab_hold", 2);
    // Abort in the cycle that would complete the match wins
    key("abwin0", 1, 1'b0);
    key("abwin1", 0, 1'b0);
    key("abwin2", 1, 1'b0);
    key("abwin3", 3, 1'b0);
    key("abwin4", 1, 1'b0);
    key("clr1", 3, 1'b0);

    // 5: code entered while open has no effect; history empty on return
    key("open0", 1, 1'b0);
    key("open1", 0, 1'b0);
    key("open2", 1, 1'b0);
    key("open3", 1, 1'b1);
    key("open_in0", 1, 1'b1);
    key("open_in1", 0, 1'b1);
    key("open_in2", 1, 1'b1);
    key("open_in3", 1, 1'b1);
    key("open_in4", 1, 1'b1);
    key("open_in5", 0, 1'b1);
    key("open_in6", 1, 1'b1);
    key("open_end", 1, 1'b0);
    // Stale 1011 would make 0,1,1 match on the third digit.
    key("empty0", 0, 1'b0);
    key("empty1", 1, 1'b0);
    key("empty2", 1, 1'b0);
    key("clr2", 3, 1'b0);

    // Reset mid-grant
    key("mid0", 1, 1'b0);
    key("mid1", 0, 1'b0);
    key("mid2", 1, 1'b0);
    key("mid3", 1, 1'b1);
    key("mid4", 2, 1'b1);
    rst = 1'b1;
    key("mid_rst", 2, 1'b0);
    rst = 1'b0;
    key("mid_after", 2, 1'b0);

    // 15 idle cycles never time out
    key("idle15_0", 1, 1'b0);
    key("idle15_1", 0, 1'b0);
    key("idle15_2", 1, 1'b0);
    for (int i = 0; i < 15; i++) key("idle15_wait", 2, 1'b0);
    key("idle15_3", 1, 1'b1);
    grant_tail("idle15_hold", 2);

    // 6: 16 idle cycles discard history only with the timeout feature
    key("idle16_0", 1, 1'b0);
    key("idle16_1", 0, 1'b0);
    key("idle16_2", 1, 1'b0);
    for (int i = 0; i < 16; i++) key("idle16_wait", 2, 1'b0);
`ifdef ELECTRONIC_LOCK_TIMEOUT_EN
    key("idle16_3", 1, 1'b0);
    key("clr3", 3, 1'b0);
`else
    key("idle16_3", 1, 1'b1);
    grant_tail("idle16_hold", 2);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/electronic_lock.md
# electronic_lock

Two-button digital combination lock. Each clock cycle in which exactly one button is asserted enters one binary digit: `b0` enters 0, `b1` enters 1. When the most recent `CODE_LEN` digits equal the programmed code, the block raises `unlock` for a fixed number of cycles and then relocks. It sits behind the debounced keypad interface and drives the latch actuator enable.

## Interface
- `CODE_LEN`, default 4: digits in the combination; legal range 1..16.
- `CODE`, default 4'b1011: combination, `CODE_LEN` bits wide; `CODE[CODE_LEN-1]` is the first digit entered.
- `UNLOCK_CYCLES`, default 8: cycles `unlock` stays high per grant; must be ≥1.
- `TIMEOUT_CYCLES`, default 16: idle cycles before entry history is discarded; used only with the timeout feature.
- `clk` in 1: single clock; all logic acts on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `b0` in 1: button 0, level sampled every cycle.
- `b1` in 1: button 1, level sampled every cycle.
- `unlock` out 1: registered; high while the lock is open.

## Operation
Input classification each cycle:
- `b0`=1, `b1`=0: digit 0.
- `b0`=0, `b1`=1: digit 1.
- Both low: idle, no effect on history.
- Both high: abort; history and count are cleared.

State machine has two states:
- LOCKED:
  - A digit shifts into a `CODE_LEN`-bit history register (new digit enters at the LSB).
  - A valid-digit counter increments and saturates at `CODE_LEN`.
  - Match condition (evaluated on the updated values): count == `CODE_LEN` and history == `CODE`.
  - On match: go to OPEN, load the open timer with `UNLOCK_CYCLES`-1, clear history and count.
  - Matching is sliding-window, so overlapping attempts succeed. Example: 1,1,0,1,1 opens on the fifth digit with the default code.
- OPEN:
  - `unlock`=1.
  - Buttons are ignored; no history accumulates.
  - Timer decrements each cycle. When it is 0, return to LOCKED with history and count clear.
- Reset: state LOCKED, `unlock`=0, history=0, count=0, all timers 0. Reset overrides every input, including mid-OPEN.

## Timing
- Digit latency: the digit sampled at edge N produces `unlock`=1 from just after edge N. It is visible in cycle N+1, so the grant has one cycle of registered latency.
- `unlock` is high for exactly `UNLOCK_CYCLES` consecutive cycles, then low.
- The first digit sampled after returning to LOCKED is accepted in that same cycle.
- One digit per cycle, maximum. A button held for k cycles enters k identical digits.
- Abort (both buttons high) in the same cycle that would complete a match wins: no unlock.
- Leaving reset: the first edge with `rst`=0 samples buttons normally.

## Configuration
- `ELECTRONIC_LOCK_TIMEOUT_EN` defined:
  - An idle counter in LOCKED counts consecutive cycles with no digit.
  - Reaching `TIMEOUT_CYCLES` clears history, count and the idle counter.
  - Any digit or abort resets the idle counter to 0.
  - The idle counter is held at 0 in OPEN.
- Undefined: no idle counter exists; history persists indefinitely.

## Structure
- Package `electronic_lock_pkg` holds:
  - the state enum `lock_state_t` {LOCKED, OPEN};
  - the digit-decode enum {DIG_NONE, DIG_0, DIG_1, DIG_ABORT};
  - the default code constant.
- One natural sub-module: `lock_input_decode`, which classifies `b0`/`b1` into the digit enum (combinational).
- History, counters and FSM live in the top-level module.

## Test plan
All scenarios use default parameters.
1. Reset high, buttons toggling -> `unlock`=0 throughout; after release the first digits build history from empty.
2. Digits 1,0,1,1 on consecutive cycles -> `unlock` high starting the cycle after the fourth digit, for exactly 8 cycles, then 0.
3. Digits 1,1,0,1,1 -> unlock follows the fifth digit (sliding-window overlap).
4. Digits 1,0, both buttons high, then 1,1 -> no unlock; a full 1,0,1,1 afterwards unlocks.
5. While OPEN, enter 1,0,1,1 again -> grant still ends after 8 cycles; no re-trigger; history empty on return.
6. With `ELECTRONIC_LOCK_TIMEOUT_EN`: digits 1,0,1, then 16 idle cycles, then 1 -> no unlock. With the macro undefined, the same stimulus -> unlock.
